// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: one-at-a-time fixed-latency arbiter between instruction fetch and load/store for a single memory (optional address check: TINKER_ARB_ADDR_CHK_EN)
module tinker_mem_arbiter #(
  parameter int              MEM_LAT  = 1,
  parameter longint unsigned MEM_SIZE = 524288,
  parameter int              STARVE_N = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic        dm_wdone,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic [63:0] mem_addr,
  output logic        mem_read_instr,
  output logic        mem_read_data,
  output logic        mem_write,
  output logic [63:0] mem_write_data,
  input  logic [31:0] mem_instr_in,
  input  logic [63:0] mem_data_in,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR, RESP} state_t;
  state_t      state;
  logic [3:0]  lat;
  logic [2:0]  starve;
  logic        is_if;
  logic        force_if;
  logic        bad;
  logic        last;
  assign force_if = starve == 3'(STARVE_N);
  assign if_gnt   = reset_n && state == IDLE && if_req && (!dm_req || force_if);
  assign dm_gnt   = reset_n && state == IDLE && dm_req && !(if_req && force_if);
  assign busy     = state != IDLE;
  assign last     = lat == 4'(MEM_LAT - 1);
`ifdef TINKER_ARB_ADDR_CHK_EN
  assign bad = if_gnt ? (if_addr[1:0] != 2'b0 || {1'b0, if_addr} + 65'd4 > 65'(MEM_SIZE))
                      : (dm_addr[2:0] != 3'b0 || {1'b0, dm_addr} + 65'd8 > 65'(MEM_SIZE));
`else
  assign bad = 1'b0;
`endif
  // Count DM wins while IF is left waiting; IF is forced once the count saturates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve <= '0;
    else starve <= (!if_req || if_gnt) ? 3'd0 : (dm_gnt && !force_if) ? starve + 3'd1 : starve;
  end
  // Access sequencer: grant in IDLE, drive memory for MEM_LAT cycles, pulse one response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat            <= '0;
      is_if          <= 1'b0;
      if_rvalid      <= 1'b0;
      if_rdata       <= '0;
      if_err         <= 1'b0;
      dm_rvalid      <= 1'b0;
      dm_wdone       <= 1'b0;
      dm_rdata       <= '0;
      dm_err         <= 1'b0;
      mem_addr       <= '0;
      mem_read_instr <= 1'b0;
      mem_read_data  <= 1'b0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_wdone  <= 1'b0;
      dm_err    <= 1'b0;
      case (state)
        IDLE: if (if_gnt || dm_gnt) begin
          is_if <= if_gnt;
          lat   <= '0;
          if (bad) begin
            if_err <= if_gnt;
            dm_err <= dm_gnt;
            state  <= RESP;
          end else if (dm_gnt && dm_we) begin
            mem_addr       <= dm_addr;
            mem_write_data <= dm_wdata;
            state          <= WR_SETUP;
          end else begin
            mem_addr       <= if_gnt ? if_addr : dm_addr;
            mem_read_instr <= if_gnt;
            mem_read_data  <= dm_gnt;
            state          <= RD;
          end
        end
        RD: if (last) begin
          if_rdata       <= is_if ? mem_instr_in : if_rdata;
          dm_rdata       <= is_if ? dm_rdata : mem_data_in;
          if_rvalid      <= is_if;
          dm_rvalid      <= !is_if;
          mem_read_instr <= 1'b0;
          mem_read_data  <= 1'b0;
          state          <= RESP;
        end else lat <= lat + 4'd1;
        WR_SETUP: begin
          mem_write <= 1'b1;
          state     <= WR;
        end
        WR: if (last) begin
          mem_write <= 1'b0;
          dm_wdone  <= 1'b1;
          state     <= RESP;
        end else lat <= lat + 4'd1;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: randomized scoreboard bench for tinker_mem_arbiter against a cycle-budget reference model
module tb_tinker_mem_arbiter;
  localparam int              LAT = 2;
  localparam int              SN  = 2;
  localparam longint unsigned MSZ = 524288;
`ifdef TINKER_ARB_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk, reset_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_wdone, dm_err;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [63:0] mem_addr, mem_write_data, mem_data_in;
  logic        mem_read_instr, mem_read_data, mem_write, busy;
  logic [31:0] mem_instr_in;

  tinker_mem_arbiter #(.MEM_LAT(LAT), .MEM_SIZE(MSZ), .STARVE_N(SN)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_wdone(dm_wdone), .dm_rdata(dm_rdata),
    .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_read_instr(mem_read_instr), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_instr_in(mem_instr_in), .mem_data_in(mem_data_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_edges = 0;
  int exp_stores = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    vectors++;
    if (act !== ex) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return i < 3 ? 8'h00 : i == 3 ? 8'hC8 : 8'(i * 73 + 11);
  endfunction

  // Bench memory: 1 KiB image aliased over the whole address space, written on mem_write rising edges
  logic [7:0] pm [1024];
  logic [9:0] ma;
  assign ma = mem_addr[9:0];
  assign mem_instr_in = {pm[ma + 10'd3], pm[ma + 10'd2], pm[ma + 10'd1], pm[ma]};
  assign mem_data_in  = {pm[ma + 10'd7], pm[ma + 10'd6], pm[ma + 10'd5], pm[ma + 10'd4],
                         pm[ma + 10'd3], pm[ma + 10'd2], pm[ma + 10'd1], pm[ma]};
  initial begin
    for (int i = 0; i < 1024; i++) pm[i] = init_byte(i);
    forever begin
      @(posedge mem_write);
      for (int k = 0; k < 8; k++) pm[ma + 10'(k)] = mem_write_data[8*k +: 8];
      wr_edges++;
    end
  end

  function automatic logic [63:0] pm_rd64(input logic [9:0] idx);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = pm[idx + 10'(k)];
    return v;
  endfunction

  // Reference model: architectural memory contents plus grant/response timing from the latency rules
  typedef struct {
    int          kind;
    int          g;
    int          due;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] data;
  } ent_t;
  ent_t q[$];
  logic [7:0] refm [1024];

  function automatic logic [63:0] ref_rd(input logic [63:0] a, input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = refm[a[9:0] + 10'(k)];
    return v;
  endfunction

  initial begin
    int   cyc, free_at, starve;
    ent_t e, ne;
    logic ri, rd, w, st_span, idle, e_if, e_dm, bad;
    logic [4:0] got, ex, one;
    cyc = 0; free_at = 0; starve = 0; one = 5'b10000;
    for (int i = 0; i < 1024; i++) refm[i] = init_byte(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        q.delete();
        free_at = 0;
        starve = 0;
        chk("rst_ctrl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, dm_wdone, if_err, dm_err, busy,
                         mem_read_instr, mem_read_data, mem_write}, 64'd0);
        chk("rst_data", {32'd0, if_rdata} | dm_rdata | mem_addr | mem_write_data, 64'd0);
        continue;
      end
      ri = 0; rd = 0; w = 0; st_span = 0;
      if (q.size() != 0) begin
        e = q[0];
        ri      = e.kind == 0 && cyc > e.g && cyc <= e.g + LAT;
        rd      = e.kind == 1 && cyc > e.g && cyc <= e.g + LAT;
        w       = e.kind == 2 && cyc >= e.g + 2 && cyc <= e.g + LAT + 1;
        st_span = e.kind == 2 && cyc > e.g && cyc <= e.g + LAT + 1;
      end
      chk("mem_en", {61'd0, mem_read_instr, mem_read_data, mem_write}, {61'd0, ri, rd, w});
      if (ri || rd || st_span) chk("mem_addr", mem_addr, e.addr);
      if (st_span) chk("mem_wdata", mem_write_data, e.wdata);
      got = {if_rvalid, dm_rvalid, dm_wdone, if_err, dm_err};
      if (got != 0 || (q.size() != 0 && q[0].due == cyc)) begin
        if (q.size() == 0) chk("resp_unexpected", 64'(got), 64'd0);
        else begin
          e = q.pop_front();
          ex = one >> e.kind;
          chk("resp_kind", 64'(got), 64'(ex));
          chk("resp_cycle", 64'(cyc), 64'(e.due));
          if (e.kind == 0) chk("if_rdata", 64'(if_rdata), e.data);
          if (e.kind == 1) chk("dm_rdata", dm_rdata, e.data);
          if (e.kind == 2) begin
            exp_stores++;
            for (int k = 0; k < 8; k++) refm[e.addr[9:0] + 10'(k)] = e.wdata[8*k +: 8];
          end
        end
      end
      idle = cyc >= free_at;
      e_if = idle && if_req && (!dm_req || starve == SN);
      e_dm = idle && dm_req && !e_if;
      chk("gnt", {62'd0, if_gnt, dm_gnt}, {62'd0, e_if, e_dm});
      chk("busy", 64'(busy), 64'(!idle));
      if (e_if || e_dm) begin
        ne.addr  = e_if ? if_addr : dm_addr;
        ne.wdata = dm_wdata;
        ne.g     = cyc;
        ne.kind  = e_if ? 0 : dm_we ? 2 : 1;
        bad = e_if ? (if_addr % 4 != 0 || if_addr + 4 > MSZ) : (dm_addr % 8 != 0 || dm_addr + 8 > MSZ);
        if (CHK && bad) ne.kind = e_if ? 3 : 4;
        ne.due  = ne.kind >= 3 ? cyc + 1 : ne.kind == 2 ? cyc + LAT + 2 : cyc + LAT + 1;
        ne.data = ne.kind == 0 ? ref_rd(ne.addr, 4) : ne.kind == 1 ? ref_rd(ne.addr, 8) : 64'd0;
        free_at = ne.due + 1;
        q.push_back(ne);
      end
      starve = (!if_req || e_if) ? 0 : (e_dm && starve < SN) ? starve + 1 : starve;
    end
  end

  task automatic if_op(input logic [63:0] a, input bit wd);
    bit g = 0;
    bit r = 0;
    if_addr = a;
    if_req = 1'b1;
    for (int i = 0; i < 300 && !g; i++) begin
      @(negedge clk);
      g = if_gnt;
      if (!g && wd) break;
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    if_addr = {$urandom, $urandom};
    if (!g) begin
      if (!wd) begin
        miscompares++;
        $display("FAIL if_gnt_timeout: got no grant expected a grant");
      end
      return;
    end
    for (int i = 0; i < 40 && !r; i++) begin
      @(negedge clk);
      r = if_rvalid || if_err;
    end
    if (!r) begin
      miscompares++;
      $display("FAIL if_resp_timeout: got no response expected a response");
    end
    @(posedge clk); #1;
  endtask

  task automatic dm_op(input logic we, input logic [63:0] a, input logic [63:0] d);
    bit g = 0;
    bit r = 0;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    dm_req = 1'b1;
    for (int i = 0; i < 300 && !g; i++) begin
      @(negedge clk);
      g = dm_gnt;
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
    dm_we = 1'($urandom);
    dm_addr = {$urandom, $urandom};
    dm_wdata = {$urandom, $urandom};
    if (!g) begin
      miscompares++;
      $display("FAIL dm_gnt_timeout: got no grant expected a grant");
      return;
    end
    for (int i = 0; i < 40 && !r; i++) begin
      @(negedge clk);
      r = dm_rvalid || dm_wdone || dm_err;
    end
    if (!r) begin
      miscompares++;
      $display("FAIL dm_resp_timeout: got no response expected a response");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pre;
    logic [63:0] old;
    bit          g;
    reset_n = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    #1 reset_n = 1'b0;
    fork
      if_op(64'h2000, 1'b0);
      dm_op(1'b0, 64'h10000, 64'd0);
      begin repeat (3) @(posedge clk); #1 reset_n = 1'b1; end
    join
    if_op(64'h2000, 1'b0);
    chk("fetch_0x2000", 64'(if_rdata), 64'hC8000000);
    fork
      repeat (3) if_op(64'h10040, 1'b0);
      repeat (6) dm_op(1'b0, 64'h10080, 64'd0);
    join
    dm_op(1'b1, 64'h10008, 64'hDEADBEEF);
    chk("store_0x10008", pm_rd64(10'h008), 64'hDEADBEEF);
    dm_op(1'b0, 64'h10008, 64'd0);
    chk("load_back", dm_rdata, 64'hDEADBEEF);
    dm_op(1'b0, 64'h10004, 64'd0);
    if_op(64'h7FFFC, 1'b0);
    if_op(64'h80000, 1'b0);
    pre = wr_edges;
    old = pm_rd64(10'h010);
    dm_we = 1'b1; dm_addr = 64'h10010; dm_wdata = ~old; dm_req = 1'b1;
    g = 0;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk);
      g = dm_gnt;
    end
    if (!g) begin
      miscompares++;
      $display("FAIL abort_gnt_timeout: got no grant expected a grant");
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("abort_edges", 64'(wr_edges), 64'(pre));
    chk("abort_mem", pm_rd64(10'h010), old);
    fork
      for (int n = 0; n < 60; n++) begin
        int gap = $urandom_range(0, 4);
        repeat (gap > 2 ? 0 : gap) begin @(posedge clk); #1; end
        if_op(64'h10000 + 64'(4 * $urandom_range(0, 255)) + ($urandom_range(0, 15) == 0 ? 64'd2 : 64'd0),
              $urandom_range(0, 7) == 0);
      end
      for (int n = 0; n < 60; n++) begin
        int gap = $urandom_range(0, 4);
        repeat (gap > 2 ? 0 : gap) begin @(posedge clk); #1; end
        dm_op(1'($urandom), 64'h10000 + 64'(8 * $urandom_range(0, 127)) + ($urandom_range(0, 15) == 0 ? 64'd4 : 64'd0),
              {$urandom, $urandom});
      end
    join
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("store_edges", 64'(wr_edges), 64'(exp_stores));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
